audio_i2s_tx: RTL and testbench
===============================

// Module: audio_i2s_tx
// PURPOSE
//   Serialises the selected oscillator sample (waveform mux output, 24-bit) into an
//   I2S stream for the board audio DAC. Generates bclk/lrck internally from the 50 MHz
//   system clock and pulls one mono sample per frame via a valid/ready handshake,
//   driving the same sample on left and right channels. Sits directly downstream of the
//   waveform mux. Sample rate is fixed by BCLK_HALF.
// PARAMETERS
//   WIDTH      24  sample width in bits, 8..32, two's complement, MSB first
//   BCLK_HALF  9   system-clock cycles per bclk half-period, >=2 (fs = 50e6/(2*BCLK_HALF*64))
// PORTS
//   clock         in   1      system clock, 50 MHz; every register on posedge
//   clear         in   1      synchronous, active-high reset
//   sample_in     in   WIDTH  sample from the waveform mux
//   sample_valid  in   1      sample_in is valid this cycle
//   sample_ready  out  1      holding register empty; transfer when valid && ready
//   bclk          out  1      I2S bit clock
//   lrck          out  1      I2S word select, 0 = left, 1 = right
//   sdata         out  1      I2S serial data, changes only on bclk falling edges
//   underrun      out  1      1-cycle pulse: frame started with no new sample
// BEHAVIOUR
//   Reset (clear=1): bclk=0, lrck=0, sdata=0, underrun=0, holding register empty,
//     frame register=0, divider=0, bit_cnt=63. sample_ready=1 first cycle after clear drops.
//   Divider: counts 0..BCLK_HALF-1; at terminal count wraps to 0 and bclk toggles.
//     First bclk rise is BCLK_HALF cycles after clear drops; first fall 2*BCLK_HALF.
//   Fall event = cycle in which bclk toggles 1->0. Only fall events update bit_cnt,
//     lrck, sdata and the frame register. Nothing changes on rise events.
//   On each fall event: b = bit_cnt+1 mod 64; bit_cnt <= b; lrck <= (b >= 32);
//     pos = (b-1) mod 32; sdata <= (pos < WIDTH) ? frame[WIDTH-1-pos] : 0.
//     sdata is computed from the frame register value before any load in the same cycle.
//     MSB therefore appears one bclk after each lrck edge (standard I2S).
//   Frame load, fall event with b=0:
//     holding full  -> frame <= holding; holding becomes empty.
//     holding empty -> frame unchanged (last sample repeated); underrun=1 for that cycle.
//   Handshake: sample_ready = holding empty. valid && ready -> holding <= sample_in,
//     full. Transfer in the same cycle as an empty-frame load still raises underrun;
//     the new sample plays from the next frame.
//   sample_in is ignored when ready=0. Holding is never overwritten; valid may be held.
//   Frame = 64 bclk = 128*BCLK_HALF clocks. bit_cnt wraps 63->0 freely.
//   clear mid-frame: all state returns to reset values next cycle, and any held sample
//     is discarded. No partial-frame recovery.
// TESTING
//   1 Reset: hold clear 3 cycles, release -> bclk=lrck=sdata=underrun=0, ready=1 next cycle.
//   2 Timing, BCLK_HALF=2: bclk period 4 clocks. lrck period 256 clocks. lrck, sdata
//     transitions only in fall-event cycles.
//   3 Data: load 24'hA50F3C before the first frame -> left slot bits b=1..24 and right
//     b=33..56 equal 1010_0101_0000_1111_0011_1100; b=25..32 and b=57..63,0 are 0.
//   4 Underrun: supply no second sample -> underrun pulses 1 cycle at the next b=0 and
//     both slots replay 24'hA50F3C. Repeats every frame until a sample arrives.
//   5 Back-pressure: hold valid with 24'h000001 then 24'hFFFFFF -> second stalls (ready=0)
//     until the b=0 load, is accepted the cycle after, and plays in the following frame.
//   6 Mid-frame clear at b=40 with holding full -> outputs reset, the held sample is
//     never transmitted, the first post-reset frame sends zeros with underrun.
//   7 WIDTH=32 -> bit 0 lands at b=32/0 and is not corrupted by the frame load.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: divides the system clock into bclk/lrck and serialises one mono sample per
// frame, MSB first, onto both channel slots. A single holding register decouples the source.
module audio_i2s_tx #(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned BCLK_HALF = 9
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             bclk,
    output logic             lrck,
    output logic             sdata,
    output logic             underrun
);

    localparam int unsigned    DivW    = $clog2(BCLK_HALF);
    localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);
    localparam logic [5:0]     WidthL  = 6'(WIDTH);

    logic [DivW-1:0]  div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             lrck_q, lrck_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] frame_q, frame_d;

    logic             div_tick;
    logic             fall;
    logic             frame_load;
    logic [5:0]       next_bit;
    logic [4:0]       pos;
    logic [WIDTH-1:0] shifted;
    logic             bit_out;

    always_comb begin
        div_tick   = (div_q == DivLast);
        fall       = div_tick && bclk_q;
        next_bit   = bit_cnt_q + 6'd1;
        frame_load = fall && (next_bit == 6'd0);
        // Slot position within the 32-bit half frame; b=0 and b=32 both map to 31.
        pos        = next_bit[4:0] - 5'd1;
        shifted    = frame_q << pos;
        bit_out    = ({1'b0, pos} < WidthL) ? shifted[WIDTH-1] : 1'b0;
    end

    always_comb begin
        div_d       = div_tick ? '0 : div_q + DivW'(1);
        bclk_d      = div_tick ? ~bclk_q : bclk_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        bit_cnt_d   = bit_cnt_q;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_d     = frame_q;

        if (fall) begin
            bit_cnt_d = next_bit;
            lrck_d    = next_bit[5];
            sdata_d   = bit_out;
        end

        if (frame_load) begin
            if (hold_full_q) begin
                frame_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Ready is the pre-edge empty flag, so a load and an accept never coincide.
        if (sample_valid && !hold_full_q) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            bit_cnt_q   <= 6'd63;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            frame_q     <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            frame_q     <= frame_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign bclk         = bclk_q;
    assign lrck         = lrck_q;
    assign sdata        = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: 24-bit and 32-bit instances at BCLK_HALF=2 checked every cycle
// against an arithmetic frame model, plus literal slot-content and timing pins.
module tb_audio_i2s_tx;

    localparam int BH = 2;

    logic        clock;
    logic        clear;
    logic [23:0] sample_in;
    logic [31:0] sample_in32;
    logic        sample_valid;
    logic        ready24, bclk24, lrck24, sdata24, underrun24;
    logic        ready32, bclk32, lrck32, sdata32, underrun32;

    audio_i2s_tx #(.WIDTH(24), .BCLK_HALF(BH)) dut (
        .clock        (clock),
        .clear        (clear),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (ready24),
        .bclk         (bclk24),
        .lrck         (lrck24),
        .sdata        (sdata24),
        .underrun     (underrun24)
    );

    audio_i2s_tx #(.WIDTH(32), .BCLK_HALF(BH)) dut32 (
        .clock        (clock),
        .clear        (clear),
        .sample_in    (sample_in32),
        .sample_valid (sample_valid),
        .sample_ready (ready32),
        .bclk         (bclk32),
        .lrck         (lrck32),
        .sdata        (sdata32),
        .underrun     (underrun32)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: edge count since clear release, holding slot and playing frame.
    int          cyc;
    logic        m_full;
    logic [23:0] m_hold24, m_frame24;
    logic [31:0] m_hold32, m_frame32;
    logic        exp_bclk, exp_lrck, exp_sd24, exp_sd32, exp_und, exp_ready;
    logic        fall_now;
    int          b_now;
    bit          model_on = 1'b0;

    function automatic logic bit_of(input logic [31:0] f, input int w, input int b);
        int          pos;
        logic [31:0] t;
        pos = (b + 31) % 32;
        if (pos >= w) return 1'b0;
        t = f >> (w - 1 - pos);
        return t[0];
    endfunction

    function automatic void model_step(input logic clr, input logic v, input logic [23:0] s24,
                                       input logic [31:0] s32);
        logic rdy;
        int   k;
        if (clr) begin
            cyc = 0; m_full = 1'b0;
            m_hold24 = '0; m_frame24 = '0; m_hold32 = '0; m_frame32 = '0;
            exp_bclk = 1'b0; exp_lrck = 1'b0; exp_sd24 = 1'b0; exp_sd32 = 1'b0;
            exp_und = 1'b0; exp_ready = 1'b1; fall_now = 1'b0;
            return;
        end
        rdy      = !m_full;
        cyc      = cyc + 1;
        exp_bclk = ((cyc / BH) % 2) == 1;
        exp_und  = 1'b0;
        fall_now = 1'b0;
        if (cyc % (2 * BH) == 0) begin
            k        = cyc / (2 * BH);
            b_now    = (k - 1) % 64;
            fall_now = 1'b1;
            exp_lrck = (b_now >= 32);
            exp_sd24 = bit_of({8'h00, m_frame24}, 24, b_now);
            exp_sd32 = bit_of(m_frame32, 32, b_now);
            if (b_now == 0) begin
                if (m_full) begin
                    m_frame24 = m_hold24;
                    m_frame32 = m_hold32;
                    m_full    = 1'b0;
                end else begin
                    exp_und = 1'b1;
                end
            end
        end
        if (v && rdy) begin
            m_hold24 = s24;
            m_hold32 = s32;
            m_full   = 1'b1;
        end
        exp_ready = !m_full;
    endfunction

    always @(negedge clock) begin
        if (model_on) begin
            chk("bclk24", bclk24, exp_bclk);
            chk("bclk32", bclk32, exp_bclk);
            chk("lrck24", lrck24, exp_lrck);
            chk("lrck32", lrck32, exp_lrck);
            chk("sdata24", sdata24, exp_sd24);
            chk("sdata32", sdata32, exp_sd32);
            chk("underrun24", underrun24, exp_und);
            chk("underrun32", underrun32, exp_und);
            chk("ready24", ready24, exp_ready);
            chk("ready32", ready32, exp_ready);
        end
    end

    logic [63:0] cap24, cap32;
    int          done_b    = -1;
    int          und_cnt   = 0;
    int          abs_cyc   = 0;
    int          last_rise = -1;
    logic        prev_l24, prev_s24, prev_l32, prev_s32;

    task automatic step();
        @(posedge clock);
        model_step(clear, sample_valid, sample_in, sample_in32);
        model_on = 1'b1;
        abs_cyc++;
        #1;
        done_b = -1;
        if (clear) begin
            last_rise = -1;
        end else begin
            if (fall_now) begin
                cap24[b_now[5:0]] = sdata24;
                cap32[b_now[5:0]] = sdata32;
                done_b = b_now;
            end else begin
                chk("stable_between_falls", {lrck24, sdata24, lrck32, sdata32},
                    {prev_l24, prev_s24, prev_l32, prev_s32});
            end
            if (underrun24) und_cnt++;
            if (lrck24 && !prev_l24) begin
                if (last_rise >= 0) chk("lrck_period", abs_cyc - last_rise, 256);
                last_rise = abs_cyc;
            end
        end
        prev_l24 = lrck24; prev_s24 = sdata24;
        prev_l32 = lrck32; prev_s32 = sdata32;
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        do begin
            step();
            n++;
        end while (done_b != target && n < 2000);
        chk("wait_b_reached", done_b, target);
    endtask

    task automatic send(input logic [23:0] s, output int stall);
        logic r;
        int   n = 0;
        sample_valid = 1'b1;
        sample_in    = s;
        sample_in32  = {s, s[15:8]};
        do begin
            r = ready24;
            step();
            n++;
        end while (!r && n < 1000);
        sample_valid = 1'b0;
        stall = n;
        chk("send_accepted", r, 1);
    endtask

    task automatic check_frame(input string name, input logic [23:0] s);
        logic [23:0] left, right;
        logic [63:0] pad;
        left = '0; right = '0; pad = cap24;
        for (int i = 1; i <= 24; i++) begin
            left  = {left[22:0], cap24[i]};
            right = {right[22:0], cap24[i + 32]};
            pad[i] = 1'b0;
            pad[i + 32] = 1'b0;
        end
        chk({name, "_left"}, left, s);
        chk({name, "_right"}, right, s);
        chk({name, "_pad"}, pad, 64'd0);
    endtask

    int stall;

    initial begin
        sample_valid = 1'b0;
        sample_in    = '0;
        sample_in32  = '0;
        clear        = 1'b1;
        cap24 = '1; cap32 = '1;
        repeat (3) step();
        chk("reset_outputs", {bclk24, lrck24, sdata24, underrun24}, 4'b0000);
        chk("reset_ready", ready24, 1);
        clear = 1'b0;
        step();
        chk("ready_after_clear", ready24, 1);
        chk("bclk_low_cycle1", bclk24, 0);
        step();
        chk("first_bclk_rise", bclk24, 1);

        // Sample loaded ahead of the first frame.
        send(24'hA50F3C, stall);
        chk("first_send_stall", stall, 1);
        wait_b(0);
        chk("no_underrun_first_load", und_cnt, 0);
        wait_b(0);
        check_frame("frame_a50f3c", 24'hA50F3C);
        chk("underrun_count_1", und_cnt, 1);
        chk("w32_bit0_b32", cap32[32], 1);
        chk("w32_bit0_b0", cap32[0], 1);

        // No new sample: frame replays.
        wait_b(0);
        check_frame("replay_a50f3c", 24'hA50F3C);
        chk("underrun_count_2", und_cnt, 2);

        // Back-pressure: second sample waits a whole frame for the holding slot.
        send(24'h000001, stall);
        chk("bp_first_stall", stall, 1);
        send(24'hFFFFFF, stall);
        chk("bp_second_stall", stall, 256);
        wait_b(0);
        check_frame("frame_000001", 24'h000001);
        chk("underrun_count_bp", und_cnt, 2);
        chk("w32_bit0_b32_zero", cap32[32], 0);
        chk("w32_bit0_b0_at_load", cap32[0], 0);
        wait_b(0);
        check_frame("frame_ffffff", 24'hFFFFFF);
        chk("underrun_count_3", und_cnt, 3);
        chk("w32_bit0_ffffff", cap32[0], 1);

        // Mid-frame clear with the holding register full.
        send(24'h123456, stall);
        wait_b(40);
        chk("ready_full_before_clear", ready24, 0);
        clear = 1'b1;
        step();
        chk("clear_outputs", {bclk24, lrck24, sdata24, underrun24}, 4'b0000);
        clear = 1'b0;
        cap24 = '1; cap32 = '1;
        wait_b(0);
        chk("underrun_after_clear", und_cnt, 4);
        wait_b(0);
        check_frame("frame_after_clear", 24'h000000);
        chk("underrun_count_5", und_cnt, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
